// File: rtl/titan_clint_if.sv
// Wishbone classic slave bundle for the core-local interruptor.
interface titan_clint_if;
    logic [15:0] wbs_addr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;

    modport master (
        output wbs_addr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o
    );

    modport slave (
        input  wbs_addr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o
    );
endinterface

// File: rtl/titan_clint.sv
// Core-local interruptor: msip register plus 64-bit mtime/mtimecmp timer,
// driving the core's software and timer interrupt lines.
module titan_clint #(
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    titan_clint_if.slave wbs,
    output logic         xint_msip_o,
    output logic         xint_mtip_o
);
    typedef enum logic [2:0] {
        REG_NONE, REG_MSIP, REG_CMP_LO, REG_CMP_HI, REG_TIME_LO, REG_TIME_HI
    } reg_sel_e;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [63:0] mtime, mtime_nxt;
    logic [63:0] mtimecmp, mtimecmp_nxt;
    logic [15:0] presc, presc_nxt;
    logic        msip, msip_nxt;
    logic        mtip_q;
    logic        ack_q, err_q;
    logic [31:0] dat_q;
    logic        req, wr;
    logic [31:0] rdata;
    reg_sel_e    reg_sel;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
        merge = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) merge[8*i +: 8] = new_v[8*i +: 8];
        end
    endfunction

    assign req = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q & ~err_q;
    assign wr  = req & wbs.wbs_we_i & (reg_sel != REG_NONE);

    always_comb begin
        reg_sel = REG_NONE;
        casez (wbs.wbs_addr_i)
            16'b0000_0000_0000_00??: reg_sel = REG_MSIP;
            16'b0100_0000_0000_00??: reg_sel = REG_CMP_LO;
            16'b0100_0000_0000_01??: reg_sel = REG_CMP_HI;
            16'b1011_1111_1111_10??: reg_sel = REG_TIME_LO;
            16'b1011_1111_1111_11??: reg_sel = REG_TIME_HI;
            default:                 reg_sel = REG_NONE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_MSIP:    rdata = {31'b0, msip};
            REG_CMP_LO:  rdata = mtimecmp[31:0];
            REG_CMP_HI:  rdata = mtimecmp[63:32];
            REG_TIME_LO: rdata = mtime[31:0];
            REG_TIME_HI: rdata = mtime[63:32];
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        msip_nxt     = msip;
        mtimecmp_nxt = mtimecmp;
        mtime_nxt    = mtime;
        presc_nxt    = presc;
        // A bus write to mtime overrides the tick and restarts the prescaler.
        if (wr && reg_sel == REG_TIME_LO) begin
            mtime_nxt = {mtime[63:32], merge(mtime[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i)};
            presc_nxt = '0;
        end else if (wr && reg_sel == REG_TIME_HI) begin
            mtime_nxt = {merge(mtime[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i), mtime[31:0]};
            presc_nxt = '0;
        end else if (presc == PRESC_MAX) begin
            mtime_nxt = mtime + 64'd1;
            presc_nxt = '0;
        end else begin
            presc_nxt = presc + 16'd1;
        end
        if (wr && reg_sel == REG_MSIP && wbs.wbs_sel_i[0]) msip_nxt = wbs.wbs_dat_i[0];
        if (wr && reg_sel == REG_CMP_LO)
            mtimecmp_nxt[31:0] = merge(mtimecmp[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i);
        if (wr && reg_sel == REG_CMP_HI)
            mtimecmp_nxt[63:32] = merge(mtimecmp[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtime    <= '0;
            mtimecmp <= MTIMECMP_RST;
            presc    <= '0;
            msip     <= 1'b0;
            mtip_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            presc    <= presc_nxt;
            msip     <= msip_nxt;
            mtip_q   <= (mtime >= mtimecmp);
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            if (req) begin
                if (reg_sel == REG_NONE) begin
                    err_q <= 1'b1;
                    dat_q <= '0;
                end else begin
                    ack_q <= 1'b1;
                    if (!wbs.wbs_we_i) dat_q <= rdata;
                end
            end
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_err_o = err_q;
    assign wbs.wbs_dat_o = dat_q;
    assign xint_msip_o   = msip;
    assign xint_mtip_o   = mtip_q;
endmodule

// File: doc/titan_clint.md
Name: titan_clint

Overview:
- Core-local interruptor; sits directly upstream of titan_core's interrupt inputs.
- Provides the machine software-interrupt register (msip) and a 64-bit machine timer (mtime/mtimecmp).
- Drives xint_msip_i and xint_mtip_i of the core.
- Accessed through a 32-bit Wishbone classic slave port, normally fed from the core's dwbm port via the system interconnect.

Parameters:
TICK_DIV, 1, clk_i cycles per mtime increment; legal range 1..65535.
MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
clk_i  input  1  system clock, all state on rising edge
rst_i  input  1  asynchronous, active-low reset
wbs_addr_i  input  16  byte offset within the block
wbs_dat_i  input  32  write data
wbs_sel_i  input  4  byte lanes
wbs_we_i  input  1  write enable
wbs_cyc_i  input  1  bus cycle
wbs_stb_i  input  1  strobe
wbs_dat_o  output  32  read data
wbs_ack_o  output  1  transfer acknowledge
wbs_err_o  output  1  transfer error
xint_msip_o  output  1  to core xint_msip_i
xint_mtip_o  output  1  to core xint_mtip_i

Behaviour:
- Reset (rst_i low, asynchronous) values:
  - mtime = 0, prescaler = 0, msip = 0, mtimecmp = MTIMECMP_RST.
  - wbs_dat_o = 0, wbs_ack_o = 0, wbs_err_o = 0, xint_msip_o = 0, xint_mtip_o = 0.
- Register map (word aligned; wbs_addr_i[1:0] ignored):
  - 0x0000: msip, bit 0 only, other bits read 0.
  - 0x4000: mtimecmp[31:0]; 0x4004: mtimecmp[63:32].
  - 0xBFF8: mtime[31:0]; 0xBFFC: mtime[63:32].
- Bus handshake:
  - Request = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o.
  - Response is registered: exactly one cycle of ack or err, one cycle after the request.
  - Ack/err deasserts the following cycle even if stb stays high, so a back-to-back transfer completes every 2 cycles.
  - Mapped address -> wbs_ack_o. Unmapped address -> wbs_err_o, no state change, wbs_dat_o = 0.
  - wbs_dat_o is valid in the ack cycle and holds its value until the next read response.
  - Writes are per byte lane under wbs_sel_i; sel = 0 still acks and changes nothing.
  - Dropping cyc while a response is pending does not cancel the response or the register update.
- Timer:
  - Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and mtime increments by 1.
  - TICK_DIV = 1 means mtime increments every cycle.
  - mtime is 64-bit and wraps from all-ones to 0.
  - A bus write to either mtime half takes priority over the increment in the same cycle; the written value is stored unincremented and the prescaler resets to 0.
  - Reads return the mtime value before that cycle's increment.
- Interrupt outputs:
  - xint_mtip_o is registered: (mtime >= mtimecmp) evaluated on post-update values, so it is visible 1 cycle after mtime/mtimecmp change.
  - Comparison is unsigned 64-bit.
  - Writing mtimecmp above mtime clears mtip on the next cycle. There is no sticky behaviour; it is a level signal.
  - xint_msip_o follows the msip register directly (registered bit).
- Simultaneous bus write and timer tick on different registers: both take effect.
- Reset asserted mid-transfer: the response is dropped and all state returns to reset values.

Test Plan:
- Reset -> all outputs 0 and mtimecmp read = 0xFFFFFFFF/0xFFFFFFFF. Release reset -> with TICK_DIV=1, reading 0xBFF8 after 10 cycles returns about 10, and the value increments on each successive read.
- Write 0x1 to 0x0000 (sel=4'hF) -> ack 1 cycle after stb, xint_msip_o=1. Write 0x0 -> xint_msip_o=0. Read 0x0000 -> 0x00000000.
- Write mtimecmp = 0x0000_0000_0000_0020 with mtime ≈ 0 -> xint_mtip_o rises exactly 1 cycle after mtime reaches 0x20. Write mtimecmp hi = 0x1 -> mtip falls 1 cycle later.
- Write mtime lo = 0xFFFFFFFF, hi = 0xFFFFFFFF -> after one tick mtime reads 0, and mtip asserts only if mtimecmp = 0.
- TICK_DIV=4 -> mtime advances by exactly 1 per 4 clk_i cycles. Writing mtime=0x100 in a tick cycle -> reads 0x100, the next increment occurs 4 cycles later.
- Access 0x1234 with stb held high for 5 cycles -> wbs_err_o pulses 1 cycle, then again 2 cycles later, no ack, registers unchanged. Byte write sel=4'b0010 data 0xAB00 to mtimecmp lo -> only bits [15:8] change.
